// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the 5-stage pipeline datapath and its hazard controller.
// master = pipeline datapath, slave = pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic [4:0]       RdM;
    logic [4:0]       RdW;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             LoadE;
    logic             PCSrcE;
    logic             McStartE;
    logic             mc_done;
    logic             imem_ready;

    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             StallE;
    logic             FlushE;
    logic             FlushM;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             mc_go;
    logic             fetch_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, LoadE, PCSrcE, McStartE, mc_done, imem_ready,
        input  StallF, StallD, FlushD, StallE, FlushE, FlushM,
        input  ForwardAE, ForwardBE, mc_go, fetch_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, LoadE, PCSrcE, McStartE, mc_done, imem_ready,
        output StallF, StallD, FlushD, StallE, FlushE, FlushM,
        output ForwardAE, ForwardBE, mc_go, fetch_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: forwarding selects, stall/flush priority, multi-cycle
// op handshake, fetch watchdog and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned FETCH_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    pipe_hazard_ctrl_if.slave        hz
);
    localparam int unsigned    WAIT_W   = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(FETCH_TIMEOUT);

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

    logic       lw_stall;
    logic       mc_active;
    logic       branch_fire;
    logic       fetch_wait;
    logic       stall_f, stall_d, stall_e;
    logic       flush_d, flush_e, flush_m;
    logic       mc_go;
    logic [1:0] fwd_a, fwd_b;

    // EX-stage operand forwarding; the younger M result beats W
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs1E))
            fwd_a = 2'b10;
        else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs1E))
            fwd_a = 2'b01;
        if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs2E))
            fwd_b = 2'b10;
        else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs2E))
            fwd_b = 2'b01;
    end

    assign lw_stall = hz.LoadE && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    // Next state and prioritised pipeline controls
    always_comb begin
        state_d     = state_q;
        mc_active   = 1'b0;
        branch_fire = 1'b0;
        fetch_wait  = 1'b0;
        mc_go       = 1'b0;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_m     = 1'b0;

        case (state_q)
            RUN: begin
                if (hz.McStartE) begin
                    state_d   = MC_BUSY;
                    mc_active = 1'b1;
                end
            end
            MC_BUSY: begin
                if (hz.mc_done) state_d = RUN;
                else            mc_active = 1'b1;
            end
            default: state_d = RUN;
        endcase

        if (reset) begin
            state_d = RUN;
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
        end else if (mc_active) begin
            // Freeze F/D/E behind the multi-cycle op, bubble into M
            mc_go   = (state_q == RUN);
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (hz.PCSrcE) begin
            branch_fire = 1'b1;
            flush_d     = 1'b1;
            flush_e     = 1'b1;
        end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else if (!hz.imem_ready) begin
            fetch_wait = 1'b1;
            stall_f    = 1'b1;
            flush_d    = 1'b1;
        end
    end

    // Watchdog and saturating performance counters
    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.imem_ready || hz.PCSrcE)
            wait_cnt_d = '0;
        else if (fetch_wait && (wait_cnt_q != WAIT_MAX))
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        fetch_err_d = fetch_err_q || (wait_cnt_d == WAIT_MAX);
        if (stall_f && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (branch_fire && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            fetch_err_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            fetch_err_q <= fetch_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.StallF    = stall_f;
    assign hz.StallD    = stall_d;
    assign hz.StallE    = stall_e;
    assign hz.FlushD    = flush_d;
    assign hz.FlushE    = flush_e;
    assign hz.FlushM    = flush_m;
    assign hz.ForwardAE = fwd_a;
    assign hz.ForwardBE = fwd_b;
    assign hz.mc_go     = mc_go;
    assign hz.fetch_err = fetch_err_q;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

endmodule
